ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
Parametrised microsequencer that generates every bus read/write strobe for the accumulator processor datapath. It generalises the fixed 14-step controller with:
- a wider, parameterised opcode space
- memory wait-state handshake
- hardware stack-depth tracking with overflow/underflow faulting
- conditional branch, I/O and HALT modes

It sits between the instruction register opcode field and the datapath (PC, IR, MAR, MDR, AC, ALU, stack, INPR/OUTR).

Parameters:
OPW, 4, opcode width; opcodes ≥ 10 are illegal.
STK_DEPTH, 8, hardware return-stack entries (power of 2, ≥ 2).
SPW, $clog2(STK_DEPTH)+1, stack-count width (derived, not overridable).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPW  IR opcode field; valid from the DECODE state onward
mem_rdy  in  1  memory has completed the current re_mem/wr_mem access
ac_zero  in  1  accumulator == 0 (for JZ)
flg_i / flg_o  in  1  input data valid / output register free
wr_pc re_pc pc_inc re_ir wr_ir re_ma wr_ma re_md wr_md wr_md_mem re_ac wr_ac re_mem wr_mem en_alu re_stck wr_stck re_inpr wr_ouR  out  1 each  registered datapath strobes
aluop  out  3  0=ADD, 1=PASS_IR_ADDR, 2=PASS_AC, 3=PASS_BUS
stk_cnt  out  SPW  live stack occupancy, 0..STK_DEPTH
halted  out  1  sticky; set by HALT
fault  out  1  sticky; set by illegal opcode or stack over/underflow
fault_code  out  2  0=none, 1=illegal, 2=overflow, 3=underflow

Behaviour:
- All outputs are registered. On rst every strobe, aluop, stk_cnt, halted, fault and fault_code go to 0, and the state goes to F0. rst mid-instruction aborts immediately; no strobe survives the reset cycle.
- Fetch, one state per cycle:
  - F0: re_pc, en_alu, aluop=3
  - F1: wr_ma
  - F2: pc_inc, re_ma
  - F3: re_mem; holds until mem_rdy=1 (wait states unbounded)
  - F4: wr_md_mem
  - F5: re_md, aluop=3
  - F6: wr_ir
  - DEC: decode
- Minimum fetch is 8 cycles. Each F3 cycle with mem_rdy=0 adds one cycle.
- DEC transitions:
  - Illegal opcode → FAULT with code 1.
  - CALL with stk_cnt==STK_DEPTH → FAULT with code 2.
  - RET with stk_cnt==0 → FAULT with code 3.
  - Otherwise go to the opcode's execute sequence.
- Execute sequences, one step per cycle; every sequence ends by returning to F0:
  - ADD 0: re_ir,aluop=1 → wr_ma → re_ma → re_mem (wait mem_rdy) → wr_md_mem,re_ac,aluop=0 → wr_ac
  - LOAD 1: same sequence, but the last two steps use aluop=1 and omit re_ac
  - STORE 2: re_ir,aluop=1 → wr_ma → re_ma → re_ac,aluop=2 → wr_md → wr_mem (held until mem_rdy)
  - CALL 3: re_pc,aluop=3 → wr_stck (stk_cnt+1) → re_ir,aluop=1 → wr_pc
  - RET 4: re_stck,aluop=3 → wr_pc,re_stck (stk_cnt−1)
  - JMP 5: re_ir,aluop=1 → wr_pc
  - JZ 6: if ac_zero, same as JMP; else a single idle cycle
  - IN 7: wait while flg_i=0; then re_inpr,aluop=3 → wr_ac
  - OUT 8: wait while flg_o=0; then re_ac,aluop=2 → wr_ouR
  - HALT 9: set halted; remain in HALT until rst
- Only the listed strobes are asserted in each step; all other strobes are 0 that cycle. wr_* and rd_* on the same bus never overlap except re_stck+wr_pc in RET.
- stk_cnt updates in the same cycle wr_stck/re_stck asserts and never wraps.
- In FAULT, all strobes are 0 and the block stays there until rst.
- Wait states (mem_rdy, flg_i, flg_o) hold the current strobes stable.

Decomposition:
- Package ctrl_seq_pkg holds:
  - opcode localparams: OP_ADD..OP_HALT, OP_LAST=9
  - aluop encodings
  - fault codes
  - state enumeration: F0..F6, DEC, E0..E5, HALT, FAULT
- Sub-module stack_counter(clk,rst,push,pop,cnt,full,empty): a saturating SPW-bit up/down counter. The sequencer instantiates one.

Test Plan:
- Reset, then LOAD (opcode 1) with mem_rdy tied 1 → fetch is exactly 8 cycles; wr_ac pulses once at cycle 14; all other strobes are 0 at that cycle.
- STORE with mem_rdy low for 3 cycles during wr_mem → wr_mem stays high for 4 cycles and then drops; the next F0 follows 1 cycle later.
- 8 CALLs (STK_DEPTH=8) → stk_cnt=8. A 9th CALL → fault=1, fault_code=2, no wr_stck. RET after rst from empty → fault_code=3.
- JZ with ac_zero=0 → no wr_pc and back to F0 after 1 cycle. JZ with ac_zero=1 → re_ir then wr_pc.
- IN with flg_i low for 5 cycles → re_inpr waits and then asserts exactly once. Opcode 12 → fault_code=1.
- rst asserted mid-ADD at the re_mem step → the next cycle all outputs are 0 and state is F0; stk_cnt=0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared opcode, ALU, fault and state encodings for the accumulator-processor
// control sequencer.
package ctrl_seq_pkg;

   // Opcode map; anything above OP_LAST is illegal
   localparam int OP_ADD   = 0;
   localparam int OP_LOAD  = 1;
   localparam int OP_STORE = 2;
   localparam int OP_CALL  = 3;
   localparam int OP_RET   = 4;
   localparam int OP_JMP   = 5;
   localparam int OP_JZ    = 6;
   localparam int OP_IN    = 7;
   localparam int OP_OUT   = 8;
   localparam int OP_HALT  = 9;
   localparam int OP_LAST  = 9;

   // ALU operation select
   localparam logic [2:0] ALU_ADD      = 3'd0;
   localparam logic [2:0] ALU_PASS_IR  = 3'd1;
   localparam logic [2:0] ALU_PASS_AC  = 3'd2;
   localparam logic [2:0] ALU_PASS_BUS = 3'd3;

   // Fault causes
   localparam logic [1:0] FLT_NONE      = 2'd0;
   localparam logic [1:0] FLT_ILLEGAL   = 2'd1;
   localparam logic [1:0] FLT_OVERFLOW  = 2'd2;
   localparam logic [1:0] FLT_UNDERFLOW = 2'd3;

   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_F3, S_F4, S_F5, S_F6,
      S_DEC,
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5,
      S_HALT, S_FAULT
   } state_t;

   // One cycle's worth of datapath strobes plus the ALU select
   typedef struct packed {
      logic       wr_pc;
      logic       re_pc;
      logic       pc_inc;
      logic       re_ir;
      logic       wr_ir;
      logic       re_ma;
      logic       wr_ma;
      logic       re_md;
      logic       wr_md;
      logic       wr_md_mem;
      logic       re_ac;
      logic       wr_ac;
      logic       re_mem;
      logic       wr_mem;
      logic       en_alu;
      logic       re_stck;
      logic       wr_stck;
      logic       re_inpr;
      logic       wr_our;
      logic [2:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/ctrl_sequencer_stack_counter.sv
// Saturating up/down occupancy counter for the hardware return stack.
module stack_counter
   import ctrl_seq_pkg::*;
#(
   parameter  int STK_DEPTH = 8,
   localparam int SPW       = $clog2(STK_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   output logic [SPW-1:0] cnt,
   output logic           full,
   output logic           empty
);

   assign full  = (cnt == SPW'(STK_DEPTH));
   assign empty = (cnt == '0);

   // Count pushes and pops, never wrapping past either end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (push && !pop && !full) begin
         cnt <= cnt + 1'b1;
      end else if (pop && !push && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microsequencer producing registered bus strobes for the accumulator
// processor: fetch with memory wait states, decode, per-opcode execute
// sequences, stack-depth tracking, HALT and sticky fault reporting.
module ctrl_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter  int OPW       = 4,
   parameter  int STK_DEPTH = 8,
   localparam int SPW       = $clog2(STK_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_rdy,
   input  logic           ac_zero,
   input  logic           flg_i,
   input  logic           flg_o,
   output logic           wr_pc,
   output logic           re_pc,
   output logic           pc_inc,
   output logic           re_ir,
   output logic           wr_ir,
   output logic           re_ma,
   output logic           wr_ma,
   output logic           re_md,
   output logic           wr_md,
   output logic           wr_md_mem,
   output logic           re_ac,
   output logic           wr_ac,
   output logic           re_mem,
   output logic           wr_mem,
   output logic           en_alu,
   output logic           re_stck,
   output logic           wr_stck,
   output logic           re_inpr,
   output logic           wr_ouR,
   output logic [2:0]     aluop,
   output logic [SPW-1:0] stk_cnt,
   output logic           halted,
   output logic           fault,
   output logic [1:0]     fault_code
);

   state_t         state_q, state_d;
   logic           boot_q;
   logic [OPW-1:0] op_q, op_d;
   logic           take_q, take_d;
   logic [1:0]     code_q, code_d;
   logic           halted_q, fault_q;
   ctrl_t          ctl_q, ctl_d;
   logic           push, pop, full, empty;
   logic           illegal;

   assign illegal = (int'(opcode) > OP_LAST);

   stack_counter #(.STK_DEPTH(STK_DEPTH)) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .cnt   (stk_cnt),
      .full  (full),
      .empty (empty)
   );

   // Strobes are computed from the next state and registered alongside it.
   // The cycle right after reset is spent with boot_q set so that F0's
   // strobes are emitted in their own cycle instead of being skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_F0;
         boot_q   <= 1'b1;
         op_q     <= '0;
         take_q   <= 1'b0;
         code_q   <= FLT_NONE;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         ctl_q    <= '0;
      end else begin
         state_q  <= state_d;
         boot_q   <= 1'b0;
         op_q     <= op_d;
         take_q   <= take_d;
         code_q   <= code_d;
         halted_q <= halted_q | (state_d == S_HALT);
         fault_q  <= fault_q | (state_d == S_FAULT);
         ctl_q    <= ctl_d;
      end
   end

   // Next-state selection, opcode/branch capture at decode and fault cause
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      take_d  = take_q;
      code_d  = code_q;
      if (state_q == S_DEC) begin
         op_d   = opcode;
         take_d = ac_zero;
      end
      if (boot_q) begin
         state_d = S_F0;
      end else begin
         case (state_q)
            S_F0:  state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = S_F3;
            S_F3:  if (mem_rdy) state_d = S_F4;
            S_F4:  state_d = S_F5;
            S_F5:  state_d = S_F6;
            S_F6:  state_d = S_DEC;
            S_DEC: begin
               if (illegal) begin
                  state_d = S_FAULT;
                  code_d  = FLT_ILLEGAL;
               end else if (int'(opcode) == OP_CALL && full) begin
                  state_d = S_FAULT;
                  code_d  = FLT_OVERFLOW;
               end else if (int'(opcode) == OP_RET && empty) begin
                  state_d = S_FAULT;
                  code_d  = FLT_UNDERFLOW;
               end else if (int'(opcode) == OP_HALT) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_E0;
               end
            end
            S_E0: begin
               case (int'(op_q))
                  OP_IN:   if (flg_i) state_d = S_E1;
                  OP_OUT:  if (flg_o) state_d = S_E1;
                  OP_JZ:   state_d = take_q ? S_E1 : S_F0;
                  default: state_d = S_E1;
               endcase
            end
            S_E1: begin
               case (int'(op_q))
                  OP_RET, OP_JMP, OP_JZ: state_d = S_F0;
                  default:               state_d = S_E2;
               endcase
            end
            S_E2: begin
               case (int'(op_q))
                  OP_IN, OP_OUT: state_d = S_F0;
                  default:       state_d = S_E3;
               endcase
            end
            S_E3: begin
               case (int'(op_q))
                  OP_CALL:         state_d = S_F0;
                  OP_ADD, OP_LOAD: if (mem_rdy) state_d = S_E4;
                  default:         state_d = S_E4;
               endcase
            end
            S_E4:  state_d = S_E5;
            S_E5: begin
               if (int'(op_q) != OP_STORE || mem_rdy) state_d = S_F0;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_F0;
         endcase
      end
   end

   // Strobe pattern for the state being entered; stack count moves with it
   always_comb begin
      ctl_d = '0;
      case (state_d)
         S_F0: begin
            ctl_d.re_pc  = 1'b1;
            ctl_d.en_alu = 1'b1;
            ctl_d.aluop  = ALU_PASS_BUS;
         end
         S_F1: ctl_d.wr_ma = 1'b1;
         S_F2: begin
            ctl_d.pc_inc = 1'b1;
            ctl_d.re_ma  = 1'b1;
         end
         S_F3: ctl_d.re_mem    = 1'b1;
         S_F4: ctl_d.wr_md_mem = 1'b1;
         S_F5: begin
            ctl_d.re_md = 1'b1;
            ctl_d.aluop = ALU_PASS_BUS;
         end
         S_F6: ctl_d.wr_ir = 1'b1;
         S_E0: begin
            case (int'(op_d))
               OP_ADD, OP_LOAD, OP_STORE, OP_JMP: begin
                  ctl_d.re_ir = 1'b1;
                  ctl_d.aluop = ALU_PASS_IR;
               end
               OP_JZ: begin
                  if (take_d) begin
                     ctl_d.re_ir = 1'b1;
                     ctl_d.aluop = ALU_PASS_IR;
                  end
               end
               OP_CALL: begin
                  ctl_d.re_pc = 1'b1;
                  ctl_d.aluop = ALU_PASS_BUS;
               end
               OP_RET: begin
                  ctl_d.re_stck = 1'b1;
                  ctl_d.aluop   = ALU_PASS_BUS;
               end
               default: ;
            endcase
         end
         S_E1: begin
            case (int'(op_d))
               OP_ADD, OP_LOAD, OP_STORE: ctl_d.wr_ma = 1'b1;
               OP_CALL:                   ctl_d.wr_stck = 1'b1;
               OP_RET: begin
                  ctl_d.wr_pc   = 1'b1;
                  ctl_d.re_stck = 1'b1;
               end
               OP_JMP, OP_JZ:             ctl_d.wr_pc = 1'b1;
               OP_IN: begin
                  ctl_d.re_inpr = 1'b1;
                  ctl_d.aluop   = ALU_PASS_BUS;
               end
               OP_OUT: begin
                  ctl_d.re_ac = 1'b1;
                  ctl_d.aluop = ALU_PASS_AC;
               end
               default: ;
            endcase
         end
         S_E2: begin
            case (int'(op_d))
               OP_ADD, OP_LOAD, OP_STORE: ctl_d.re_ma = 1'b1;
               OP_CALL: begin
                  ctl_d.re_ir = 1'b1;
                  ctl_d.aluop = ALU_PASS_IR;
               end
               OP_IN:   ctl_d.wr_ac  = 1'b1;
               OP_OUT:  ctl_d.wr_our = 1'b1;
               default: ;
            endcase
         end
         S_E3: begin
            case (int'(op_d))
               OP_ADD, OP_LOAD: ctl_d.re_mem = 1'b1;
               OP_STORE: begin
                  ctl_d.re_ac = 1'b1;
                  ctl_d.aluop = ALU_PASS_AC;
               end
               OP_CALL: ctl_d.wr_pc = 1'b1;
               default: ;
            endcase
         end
         S_E4: begin
            case (int'(op_d))
               OP_ADD: begin
                  ctl_d.wr_md_mem = 1'b1;
                  ctl_d.re_ac     = 1'b1;
                  ctl_d.aluop     = ALU_ADD;
               end
               OP_LOAD: begin
                  ctl_d.wr_md_mem = 1'b1;
                  ctl_d.aluop     = ALU_PASS_IR;
               end
               OP_STORE: ctl_d.wr_md = 1'b1;
               default: ;
            endcase
         end
         S_E5: begin
            case (int'(op_d))
               OP_ADD:   ctl_d.wr_ac = 1'b1;
               OP_LOAD: begin
                  ctl_d.wr_ac = 1'b1;
                  ctl_d.aluop = ALU_PASS_IR;
               end
               OP_STORE: ctl_d.wr_mem = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
      push = ctl_d.wr_stck;
      pop  = ctl_d.re_stck && (state_d == S_E1);
   end

   assign wr_pc      = ctl_q.wr_pc;
   assign re_pc      = ctl_q.re_pc;
   assign pc_inc     = ctl_q.pc_inc;
   assign re_ir      = ctl_q.re_ir;
   assign wr_ir      = ctl_q.wr_ir;
   assign re_ma      = ctl_q.re_ma;
   assign wr_ma      = ctl_q.wr_ma;
   assign re_md      = ctl_q.re_md;
   assign wr_md      = ctl_q.wr_md;
   assign wr_md_mem  = ctl_q.wr_md_mem;
   assign re_ac      = ctl_q.re_ac;
   assign wr_ac      = ctl_q.wr_ac;
   assign re_mem     = ctl_q.re_mem;
   assign wr_mem     = ctl_q.wr_mem;
   assign en_alu     = ctl_q.en_alu;
   assign re_stck    = ctl_q.re_stck;
   assign wr_stck    = ctl_q.wr_stck;
   assign re_inpr    = ctl_q.re_inpr;
   assign wr_ouR     = ctl_q.wr_our;
   assign aluop      = ctl_q.aluop;
   assign halted     = halted_q;
   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule
